// File: rtl/decoder_xor_sweeper.sv
// decoder_xor_sweeper: on-chip exhaustive sweep of a 4-input XOR block.
//   Drives {a,b,c,d} through codes 0..15, holds each for DWELL cycles and
//   compares e with the expected parity at the end of each dwell.
// Ports: clk/rst (async, active-high); start request; e = XOR output under
//   check; a..d/code = driven code; busy/done/pass/err_count = sweep status.
//   Optional (SWEEP_FAIL_LOG_EN): first_fail_valid/first_fail_code record the
//   first failing code of a sweep.
module decoder_xor_sweeper #(
  parameter int DWELL = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       e,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] code,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count
`ifdef SWEEP_FAIL_LOG_EN
  ,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_code
`endif
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    code_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    err_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;

`ifdef SWEEP_FAIL_LOG_EN
  logic          ff_vld_q;
  logic [3:0]    ff_code_q;
`endif

  logic          sample;
  logic          mismatch;
  logic [4:0]    err_d;

  // Mismatch and the post-compare error count are computed combinationally so
  // the final compare of the sweep is folded into the pass verdict.
  always_comb begin
    sample   = (cnt_q == LAST);
    mismatch = (e != ^code_q);
    err_d    = err_q;
    if (mismatch) begin
      err_d = err_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      code_q    <= 4'd0;
      cnt_q     <= '0;
      err_q     <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef SWEEP_FAIL_LOG_EN
      ff_vld_q  <= 1'b0;
      ff_code_q <= 4'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          code_q <= 4'd0;
          if (start) begin
            state_q   <= S_DRIVE;
            cnt_q     <= '0;
            err_q     <= 5'd0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b1;
`ifdef SWEEP_FAIL_LOG_EN
            ff_vld_q  <= 1'b0;
            ff_code_q <= 4'd0;
`endif
          end
        end
        S_DRIVE: begin
          if (sample) begin
            cnt_q <= '0;
            err_q <= err_d;
`ifdef SWEEP_FAIL_LOG_EN
            // Only the first failing code of a sweep is kept.
            if (mismatch && !ff_vld_q) begin
              ff_vld_q  <= 1'b1;
              ff_code_q <= code_q;
            end
`endif
            if (code_q == 4'd15) begin
              // code stays at 15 through DONE.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 5'd0);
            end else begin
              code_q <= code_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          code_q  <= 4'd0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          code_q  <= 4'd0;
        end
      endcase
    end
  end

  assign a         = code_q[3];
  assign b         = code_q[2];
  assign c         = code_q[1];
  assign d         = code_q[0];
  assign code      = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef SWEEP_FAIL_LOG_EN
  assign first_fail_valid = ff_vld_q;
  assign first_fail_code  = ff_code_q;
`endif

endmodule

// File: tb/tb_decoder_xor_sweeper.sv
// Directed bench for decoder_xor_sweeper: a DWELL=4 instance exercises the
// correct / inverted / stuck-at-0 XOR models, start re-pulse and mid-sweep
// reset; a DWELL=2 instance runs back-to-back sweeps with start held high.
module tb_decoder_xor_sweeper;

  logic       clk;
  logic       rst;
  logic       start;
  logic       e;
  logic       a, b, c, d;
  logic [3:0] code;
  logic       busy, done, pass;
  logic [4:0] err_count;

  logic       start2;
  logic       e2;
  logic       a2, b2, c2, d2;
  logic [3:0] code2;
  logic       busy2, done2, pass2;
  logic [4:0] err2;

`ifdef SWEEP_FAIL_LOG_EN
  logic       ffv, ffv2;
  logic [3:0] ffc, ffc2;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: correct XOR, 1: inverted, 2: stuck at 0

  assign e  = (mode == 0) ? (a ^ b ^ c ^ d) :
              (mode == 1) ? ~(a ^ b ^ c ^ d) : 1'b0;
  assign e2 = a2 ^ b2 ^ c2 ^ d2;

  decoder_xor_sweeper #(.DWELL(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .e(e),
    .a(a), .b(b), .c(c), .d(d), .code(code),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef SWEEP_FAIL_LOG_EN
    , .first_fail_valid(ffv), .first_fail_code(ffc)
`endif
  );

  decoder_xor_sweeper #(.DWELL(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .e(e2),
    .a(a2), .b(b2), .c(c2), .d(d2), .code(code2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef SWEEP_FAIL_LOG_EN
    , .first_fail_valid(ffv2), .first_fail_code(ffc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise start, let one edge accept it, drop it; returns at acceptance edge +1.
  task automatic start_sweep();
    start = 1'b1;
    run(1);
    start = 1'b0;
  endtask

  initial begin
    int done_cnt;
    int last_done;
    int n_done;

    rst    = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    #2 rst = 1'b1;
    #2;
    // Reset state
    chk("rst_code", code, 0);
    chk("rst_abcd", {a, b, c, d}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst2_busy", busy2, 0);
`ifdef SWEEP_FAIL_LOG_EN
    chk("rst_ffv", ffv, 0);
    chk("rst_ffc", ffc, 0);
`endif
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    run(2);
    chk("idle_busy", busy, 0);

    // Correct model: 64-cycle sweep, code steps every 4 cycles
    mode = 0;
    start_sweep();
    chk("ok_acc_busy", busy, 1);
    chk("ok_acc_code", code, 0);
    for (int j = 1; j < 64; j++) begin
      run(1);
      chk($sformatf("ok_code_%0d", j), {a, b, c, d}, j / 4);
      chk($sformatf("ok_busy_%0d", j), {busy, done}, 2'b10);
    end
    run(1);
    chk("ok_done", done, 1);
    chk("ok_done_busy", busy, 0);
    chk("ok_done_code", code, 15);
    chk("ok_err", err_count, 0);
    chk("ok_pass", pass, 1);
`ifdef SWEEP_FAIL_LOG_EN
    chk("ok_ffv", ffv, 0);
`endif
    run(1);
    chk("ok_post_done", done, 0);
    chk("ok_post_code", code, 0);
    chk("ok_post_pass", pass, 1);

    // Inverted model: every compare fails
    mode = 1;
    start_sweep();
    chk("inv_acc_pass", pass, 0);
    chk("inv_acc_err", err_count, 0);
    run(63);
    chk("inv_pre_done", done, 0);
    chk("inv_err_15", err_count, 15);
    run(1);
    chk("inv_done", done, 1);
    chk("inv_err", err_count, 16);
    chk("inv_pass", pass, 0);
`ifdef SWEEP_FAIL_LOG_EN
    chk("inv_ffv", ffv, 1);
    chk("inv_ffc", ffc, 0);
`endif
    run(1);

    // Stuck-at-0: only odd-parity codes fail (8 of them, first is 1)
    mode = 2;
    start_sweep();
    chk("s0_acc_err", err_count, 0);
    chk("s0_acc_pass", pass, 0);
`ifdef SWEEP_FAIL_LOG_EN
    chk("s0_acc_ffv", ffv, 0);
`endif
    run(64);
    chk("s0_done", done, 1);
    chk("s0_err", err_count, 8);
    chk("s0_pass", pass, 0);
`ifdef SWEEP_FAIL_LOG_EN
    chk("s0_ffv", ffv, 1);
    chk("s0_ffc", ffc, 1);
`endif
    run(1);

    // Start re-pulsed during DRIVE at code 5 is ignored
    mode = 0;
    start_sweep();
    chk("rp_acc_err", err_count, 0);
    run(20);
    chk("rp_code5", code, 5);
    start = 1'b1;
    run(1);
    start = 1'b0;
    chk("rp_code5_hold", code, 5);
    run(3);
    chk("rp_code6", code, 6);
    run(39);
    chk("rp_pre_done", {busy, done, code}, {2'b10, 4'd15});
    run(1);
    chk("rp_done", done, 1);
    chk("rp_err", err_count, 0);
    chk("rp_pass", pass, 1);
    run(1);

    // Asynchronous reset mid-dwell at code 7
    mode = 2;
    start_sweep();
    run(30);
    chk("mr_code7", code, 7);
    chk("mr_err3", err_count, 3);
    #3 rst = 1'b1;
    #1;
    chk("mr_code", code, 0);
    chk("mr_abcd", {a, b, c, d}, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_pass", pass, 0);
    chk("mr_err", err_count, 0);
    #2 rst = 1'b0;
    done_cnt = 0;
    for (int j = 0; j < 70; j++) begin
      run(1);
      if (done || busy) done_cnt++;
    end
    chk("mr_no_resume", done_cnt, 0);

    // DWELL=2, start held high: sweeps every 16*2+2 cycles, each passing
    start2    = 1'b1;
    last_done = -1;
    n_done    = 0;
    for (int j = 1; j <= 120; j++) begin
      run(1);
      if (done2) begin
        n_done++;
        chk($sformatf("b2b_pass_%0d", n_done), pass2, 1);
        chk($sformatf("b2b_busy_%0d", n_done), busy2, 0);
        chk($sformatf("b2b_err_%0d", n_done), err2, 0);
        if (last_done < 0) chk("b2b_first_at", j, 33);
        else chk($sformatf("b2b_gap_%0d", n_done), j - last_done, 34);
        last_done = j;
      end
    end
    chk("b2b_count", n_done, 3);
    start2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_xor_sweeper.md
# decoder_xor_sweeper

Self-checking stimulus sequencer that sits directly upstream of the decoder-based 4-input XOR block (`XOR_using_Decoder`) and consumes its output.
- On a start request it drives the XOR block's four inputs `a`, `b`, `c`, `d` through all 16 codes 0000..1111, with `a` as MSB.
- Each code is held for a programmable dwell time; at the end of the dwell it samples the XOR output `e` and compares it against the expected 4-input parity.
- It reports a mismatch count and a pass/fail verdict, replacing the fixed-delay exhaustive sweep with an on-chip synthesizable equivalent.

## Interface
Parameters:
- `DWELL`, default 10 — clock cycles each code is held; legal range 2..256.

Ports (clock and reset first):
- `clk`  in  1  — sole clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `start`  in  1  — sweep request; sampled only in IDLE.
- `e`  in  1  — XOR block output under check; combinational from `a`..`d`.
- `a`, `b`, `c`, `d`  out  1 each  — XOR block inputs; `{a,b,c,d}` equals `code`.
- `code`  out  4  — current code being driven.
- `busy`  out  1  — high while sweeping.
- `done`  out  1  — one-cycle pulse when a sweep finishes.
- `pass`  out  1  — high when the last completed sweep had zero mismatches; held until the next start.
- `err_count`  out  5  — mismatches in the current or last sweep, 0..16.

## Operation
- States:
  - IDLE: `busy`=0, `code` held at 0.
  - DRIVE: `busy`=1.
  - DONE: lasts exactly one cycle, `done`=1.
- IDLE -> DRIVE when `start`=1 at a rising edge. On that edge: `code`<=0, dwell counter<=0, `err_count`<=0, `pass`<=0.
- In DRIVE the dwell counter (width clog2(DWELL)) increments each edge.
- At the edge where counter==DWELL-1 (the sample edge):
  - compare `e` against the XOR-reduction of `code`; on mismatch `err_count`<=`err_count`+1;
  - counter<=0;
  - if `code`==15: go to DONE; otherwise `code`<=`code`+1.
- DONE -> IDLE unconditionally. On the DRIVE->DONE edge `pass`<=(final `err_count`==0); the final compare is included.
- `code` does not wrap to 0 at the end of the sweep: it stays 15 through DONE and returns to 0 on the DONE->IDLE edge.
- `start` is ignored in DRIVE and DONE; it is not queued. Holding `start` high starts a new sweep on the first IDLE edge after DONE.
- `err_count` cannot overflow: at most 16 compares per sweep, and 5 bits are sufficient.

## Timing
- Reset values:
  - state IDLE, `code`=0, `a`..`d`=0;
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0;
  - dwell counter 0; log registers as listed under Configuration.
- Reset asserted mid-sweep returns all of the above immediately, regardless of `clk`. No sweep resumes after deassertion without a new `start`.
- Start accepted at edge k:
  - code n is driven from edge k+n·DWELL and sampled at edge k+(n+1)·DWELL;
  - `done` is high in the cycle after edge k+16·DWELL, and `busy` is low in that same cycle.
- Total sweep latency: 16·DWELL cycles from start acceptance to `done`.
- `a`..`d` are registered outputs. `e` must settle within DWELL-1 cycles; it is only observed at the sample edge.

## Configuration
- Macro `SWEEP_FAIL_LOG_EN`.
- Defined: adds outputs `first_fail_valid` (out, 1) and `first_fail_code` (out, 4).
  - On the first mismatch of a sweep they latch `code`, and `first_fail_valid`<=1.
  - Later mismatches in the same sweep do not change them.
  - Both are cleared to 0 by reset and by start acceptance.
- Undefined: neither port exists and no logging registers are built. All other behaviour is identical.

## Test plan
- Correct XOR model, DWELL=4, `start` pulsed at edge k -> `busy` high for 64 cycles, `done` high in the cycle after edge k+64, `err_count`=0, `pass`=1; `{a,b,c,d}` steps 0..15 every 4 cycles.
- Inverted model (`e`=~parity), DWELL=4 -> `err_count`=16, `pass`=0; with the macro, `first_fail_code`=0 and `first_fail_valid`=1.
- `e` stuck at 0 -> `err_count`=8, `pass`=0; with the macro, `first_fail_code`=1.
- `rst` asserted while `code`=7 mid-dwell -> all outputs at reset values immediately; `done` never pulses for that sweep.
- `start` re-pulsed at code 5 during DRIVE -> ignored, sweep completes unchanged in 16·DWELL cycles. After a failed sweep, a new `start` clears `err_count` to 0 and `pass` to 0 on the acceptance edge.
- DWELL=2 with `start` held constantly high -> back-to-back sweeps separated by exactly one DONE cycle and one IDLE acceptance edge; each sweep reports `pass`=1.
